// File: rtl/fp_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fp_mul_arbiter
//
// Purpose
//   Shares one pipelined single-precision FP multiplier IP between NREQ map
//   engines. Requests are served round-robin, at most one product is issued
//   per cycle, and a tag pipeline that mirrors the multiplier latency routes
//   every result back to the requester that issued it.
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   flush      in   synchronous: drop all in-flight products, re-clear the IP
//   req        in   [NREQ]    per-requester request, held until granted
//   req_a      in   [NREQ*W]  operand A, requester i at [i*W +: W]
//   req_b      in   [NREQ*W]  operand B, same packing
//   gnt        out  [NREQ]    one-hot grant (combinational)
//   mul_a      out  [W]       multiplier dataa (registered)
//   mul_b      out  [W]       multiplier datab (registered)
//   mul_en     out            multiplier clk_en (registered)
//   mul_aclr   out            multiplier aclr (registered)
//   mul_result in   [W]       multiplier result
//   rsp_valid  out            one-cycle strobe, rsp_id/rsp_data valid
//   rsp_id     out  [IDW]     owner of rsp_data
//   rsp_data   out  [W]       product, mul_result passed straight through
//   busy       out            high while not in RUN or any product in flight
// ---------------------------------------------------------------------------
module fp_mul_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int LAT  = 8,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_en,
  output logic              mul_aclr,
  input  logic [W-1:0]      mul_result,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t         state;
  logic           init_cnt;   // INIT holds the IP in clear for two cycles
  logic [IDW-1:0] ptr;        // round-robin search start

  // Operands unpacked per requester so the issue mux is a plain array index.
  logic [W-1:0]   op_a [NREQ];
  logic [W-1:0]   op_b [NREQ];

  // Arbitration results.
  logic           arb_en;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] ptr_next;
  logic           issue;

  // Tag pipe: stage 0 is loaded at the edge that ends the grant cycle, so
  // stage LAT lines up with the cycle the multiplier presents the product.
  logic [LAT:0]   tag_valid;
  logic [IDW-1:0] tag_id [LAT+1];
  logic           pipe_clr;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ops
      assign op_a[gi] = req_a[gi*W +: W];
      assign op_b[gi] = req_b[gi*W +: W];
    end
  endgenerate

  // Only RUN arbitrates, and a flush cycle grants nothing.
  assign arb_en = (state == ST_RUN) && !flush;

  // Rotating priority search starting at ptr; first asserted request wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign ptr_next = IDW'((int'(gnt_idx) + 1) % NREQ);
  assign issue    = arb_en && gnt_any;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign gnt[gi] = issue && (gnt_idx == IDW'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control FSM. mul_en/mul_aclr are registered from the next state so the IP
  // sees clean, glitch-free control levels.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= 1'b0;
      ptr      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_en   <= 1'b0;
      mul_aclr <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt) begin
            state    <= ST_RUN;
            init_cnt <= 1'b0;
            mul_en   <= 1'b1;
            mul_aclr <= 1'b0;
          end else begin
            init_cnt <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state    <= ST_FLUSH;
            mul_en   <= 1'b0;
            mul_aclr <= 1'b1;
          end else if (gnt_any) begin
            ptr   <= ptr_next;
            mul_a <= op_a[gnt_idx];
            mul_b <= op_b[gnt_idx];
          end
        end
        ST_FLUSH: begin
          state    <= ST_RUN;
          mul_en   <= 1'b1;
          mul_aclr <= 1'b0;
        end
        default: begin
          state    <= ST_INIT;
          init_cnt <= 1'b0;
          mul_en   <= 1'b0;
          mul_aclr <= 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Tag pipeline. A flush clears every stage at the edge ending the flush
  // cycle: the tag already at the output in that cycle has been emitted,
  // everything still inside the pipe is dropped together with the IP clear.
  // -------------------------------------------------------------------------
  assign pipe_clr = (state != ST_RUN) || flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      for (int i = 0; i <= LAT; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      if (pipe_clr) begin
        tag_valid <= '0;
      end else begin
        tag_valid <= {tag_valid[LAT-1:0], issue};
      end
      tag_id[0] <= gnt_idx;
      for (int i = 1; i <= LAT; i++) begin
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign rsp_valid = tag_valid[LAT];
  assign rsp_id    = tag_id[LAT];
  assign rsp_data  = mul_result;
  assign busy      = (state != ST_RUN) || (|tag_valid);

  // -------------------------------------------------------------------------
  // Structural properties.
  // -------------------------------------------------------------------------
  a_gnt_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(gnt));

  a_gnt_only_run : assert property (@(posedge clk) disable iff (reset)
    (gnt != '0) |-> (state == ST_RUN && !flush));

  a_gnt_has_req : assert property (@(posedge clk) disable iff (reset)
    ((gnt & ~req) == '0));

  a_ctrl_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(mul_en && mul_aclr));

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_arbiter
//   Directed bench for fp_mul_arbiter. Two instances: NREQ=2 for the main
//   scenarios and NREQ=3 for the wrap-around search. Each instance drives a
//   behavioural LAT-stage multiplier that really multiplies (normal numbers,
//   round to nearest even) so routed products can be compared bit-exact.
// ---------------------------------------------------------------------------
module tb_fp_mul_arbiter;
  localparam int W   = 32;
  localparam int LAT = 8;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- NREQ=2 instance ----------------
  logic [1:0]     req2;
  logic [2*W-1:0] req2_a, req2_b;
  logic [1:0]     gnt2;
  logic [W-1:0]   mul2_a, mul2_b, mul2_result, rsp2_data;
  logic           mul2_en, mul2_aclr, rsp2_valid, busy2;
  logic [0:0]     rsp2_id;

  fp_mul_arbiter #(.NREQ(2), .W(W), .LAT(LAT), .IDW(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req(req2), .req_a(req2_a), .req_b(req2_b), .gnt(gnt2),
    .mul_a(mul2_a), .mul_b(mul2_b), .mul_en(mul2_en), .mul_aclr(mul2_aclr),
    .mul_result(mul2_result),
    .rsp_valid(rsp2_valid), .rsp_id(rsp2_id), .rsp_data(rsp2_data),
    .busy(busy2)
  );

  // ---------------- NREQ=3 instance ----------------
  logic [2:0]     req3;
  logic [3*W-1:0] req3_a, req3_b;
  logic [2:0]     gnt3;
  logic [W-1:0]   mul3_a, mul3_b, mul3_result, rsp3_data;
  logic           mul3_en, mul3_aclr, rsp3_valid, busy3;
  logic [1:0]     rsp3_id;

  fp_mul_arbiter #(.NREQ(3), .W(W), .LAT(LAT), .IDW(2)) dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .req(req3), .req_a(req3_a), .req_b(req3_b), .gnt(gnt3),
    .mul_a(mul3_a), .mul_b(mul3_b), .mul_en(mul3_en), .mul_aclr(mul3_aclr),
    .mul_result(mul3_result),
    .rsp_valid(rsp3_valid), .rsp_id(rsp3_id), .rsp_data(rsp3_data),
    .busy(busy3)
  );

  // ---------------- reference FP multiply ----------------
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [23:0] m;
    logic        g, s;
    int          e;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; s = |p[22:0]; e = e + 1;
    end else begin
      m = p[46:23]; g = p[22]; s = |p[21:0];
    end
    if (g && (s || m[0])) begin
      if (m == 24'hFFFFFF) begin
        m = 24'h800000; e = e + 1;
      end else begin
        m = m + 24'd1;
      end
    end
    return {a[31] ^ b[31], e[7:0], m[22:0]};
  endfunction

  // ---------------- behavioural multiplier IPs ----------------
  logic [W-1:0] pipe2 [LAT];
  logic [W-1:0] pipe3 [LAT];

  always @(posedge clk or posedge mul2_aclr) begin
    if (mul2_aclr) begin
      for (int i = 0; i < LAT; i++) pipe2[i] <= '0;
    end else if (mul2_en) begin
      pipe2[0] <= fp_mul(mul2_a, mul2_b);
      for (int i = 1; i < LAT; i++) pipe2[i] <= pipe2[i-1];
    end
  end
  assign mul2_result = pipe2[LAT-1];

  always @(posedge clk or posedge mul3_aclr) begin
    if (mul3_aclr) begin
      for (int j = 0; j < LAT; j++) pipe3[j] <= '0;
    end else if (mul3_en) begin
      pipe3[0] <= fp_mul(mul3_a, mul3_b);
      for (int j = 1; j < LAT; j++) pipe3[j] <= pipe3[j-1];
    end
  end
  assign mul3_result = pipe3[LAT-1];

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Responses seen on the NREQ=2 instance and ops the bench expects back.
  typedef struct { int c; int id; logic [31:0] d; } rsp_t;
  typedef struct { int c; int id; logic [31:0] a; logic [31:0] b; } op_t;
  rsp_t rq[$];
  op_t  eq[$];

  always @(negedge clk) begin
    if (rsp2_valid) rq.push_back('{cyc, int'(rsp2_id), rsp2_data});
  end

  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) drv_edge();
  endtask

  task automatic verify_rsp(input string tag);
    check({tag, "_cnt"}, 64'(rq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < rq.size(); i++) begin
      $display("%s rsp %0d: cyc=%0d id=%0d data=%08h", tag, i, rq[i].c, rq[i].id, rq[i].d);
      check({tag, "_cyc"},  64'(rq[i].c),  64'(eq[i].c + 1 + LAT));
      check({tag, "_id"},   64'(rq[i].id), 64'(eq[i].id));
      check({tag, "_data"}, 64'(rq[i].d),  64'(fp_mul(eq[i].a, eq[i].b)));
    end
    rq.delete();
    eq.delete();
  endtask

  // Operand table for the contention scenario (all normal numbers).
  logic [31:0] opa [6];
  logic [31:0] opb [6];
  logic [1:0]  exp_g2 [4];
  logic [2:0]  exp_g3 [4];
  logic [1:0]  exp_id3 [4];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    opa[0] = 32'h3fc00000; opb[0] = 32'h40000000;  // 1.5 * 2
    opa[1] = 32'h40400000; opb[1] = 32'h3f000000;  // 3 * 0.5
    opa[2] = 32'hc0a00000; opb[2] = 32'h3e800000;  // -5 * 0.25
    opa[3] = 32'h3f5645a2; opb[3] = 32'h40492492;
    opa[4] = 32'h41200000; opb[4] = 32'h41200000;  // 10 * 10
    opa[5] = 32'h3dcccccd; opb[5] = 32'h3dcccccd;  // 0.1 * 0.1
    exp_g2[0] = 2'b01; exp_g2[1] = 2'b10; exp_g2[2] = 2'b01; exp_g2[3] = 2'b10;
    exp_g3[0] = 3'b100; exp_g3[1] = 3'b001; exp_g3[2] = 3'b010; exp_g3[3] = 3'b100;
    exp_id3[0] = 2'd2; exp_id3[1] = 2'd0; exp_id3[2] = 2'd1; exp_id3[3] = 2'd2;

    reset = 1'b1; flush = 1'b0;
    req2 = '0; req2_a = '0; req2_b = '0;
    req3 = '0; req3_a = '0; req3_b = '0;

    // ---- reset state ----
    smp(); smp();
    $display("reset: gnt=%b rsp_valid=%b en=%b aclr=%b busy=%b", gnt2, rsp2_valid, mul2_en, mul2_aclr, busy2);
    check("rst_gnt", 64'(gnt2), 64'd0);
    check("rst_rsp_valid", 64'(rsp2_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp2_id), 64'd0);
    check("rst_mul_en", 64'(mul2_en), 64'd0);
    check("rst_mul_aclr", 64'(mul2_aclr), 64'd1);
    check("rst_busy", 64'(busy2), 64'd1);
    check("rst_mul_a", 64'(mul2_a), 64'd0);
    drv_edge();
    req2 = 2'b11;
    req2_a[0 +: 32] = opa[0]; req2_b[0 +: 32] = opb[0];
    req2_a[32 +: 32] = opa[1]; req2_b[32 +: 32] = opb[1];
    smp();
    check("rst_gnt_req", 64'(gnt2), 64'd0);

    // ---- 1: release into INIT, two cycles of clear ----
    drv_edge();
    reset = 1'b0;
    smp();
    $display("init1: gnt=%b en=%b aclr=%b", gnt2, mul2_en, mul2_aclr);
    check("init1_aclr", 64'(mul2_aclr), 64'd1);
    check("init1_en", 64'(mul2_en), 64'd0);
    check("init1_gnt", 64'(gnt2), 64'd0);
    check("init1_busy", 64'(busy2), 64'd1);
    drv_edge();
    smp();
    $display("init2: gnt=%b en=%b aclr=%b", gnt2, mul2_en, mul2_aclr);
    check("init2_aclr", 64'(mul2_aclr), 64'd1);
    check("init2_gnt", 64'(gnt2), 64'd0);

    // ---- 3: contention, req=11 held from ptr=0 ----
    for (int k = 0; k < 4; k++) begin
      drv_edge();
      if (k > 0) begin
        req2_a[((k-1)%2)*32 +: 32] = opa[k+1];
        req2_b[((k-1)%2)*32 +: 32] = opb[k+1];
      end
      smp();
      $display("t3 cyc=%0d gnt=%b en=%b aclr=%b", cyc, gnt2, mul2_en, mul2_aclr);
      check("t3_gnt", 64'(gnt2), 64'(exp_g2[k]));
      if (k == 0) begin
        check("t3_run_en", 64'(mul2_en), 64'd1);
        check("t3_run_aclr", 64'(mul2_aclr), 64'd0);
      end
      eq.push_back('{cyc, k % 2, opa[k], opb[k]});
    end
    drv_edge();
    req2 = 2'b00;
    smp();
    check("t3_busy", 64'(busy2), 64'd1);
    wait_cycles(14);
    smp();
    check("t3_idle_busy", 64'(busy2), 64'd0);
    verify_rsp("t3");

    // ---- 2: single op from requester 0 ----
    drv_edge();
    req2 = 2'b01;
    req2_a[0 +: 32] = 32'h3f5645a2; req2_b[0 +: 32] = 32'h40492492;
    smp();
    $display("t2 cyc=%0d gnt=%b", cyc, gnt2);
    check("t2_gnt", 64'(gnt2), 64'b01);
    eq.push_back('{cyc, 0, 32'h3f5645a2, 32'h40492492});
    drv_edge();
    req2 = 2'b00;
    smp();
    check("t2_gnt_off", 64'(gnt2), 64'd0);
    wait_cycles(12);
    if (rq.size() > 0) check("t2_hand_product", 64'(rq[0].d), 64'h40285b48);
    verify_rsp("t2");

    // ---- 5: flush with 5 ops in flight ----
    req2_a[0 +: 32] = opa[4]; req2_b[0 +: 32] = opb[4];
    for (int k = 0; k < 5; k++) begin
      drv_edge();
      req2 = 2'b01;
      smp();
      $display("t5 cyc=%0d gnt=%b", cyc, gnt2);
      check("t5_gnt", 64'(gnt2), 64'b01);
    end
    drv_edge();
    flush = 1'b1;
    smp();
    $display("t5 flush cyc=%0d gnt=%b", cyc, gnt2);
    check("t5_flush_gnt", 64'(gnt2), 64'd0);
    check("t5_flush_busy", 64'(busy2), 64'd1);
    drv_edge();
    flush = 1'b0;
    req2 = 2'b00;
    smp();
    $display("t5 FLUSH state: en=%b aclr=%b busy=%b", mul2_en, mul2_aclr, busy2);
    check("t5_fl_aclr", 64'(mul2_aclr), 64'd1);
    check("t5_fl_en", 64'(mul2_en), 64'd0);
    check("t5_fl_gnt", 64'(gnt2), 64'd0);
    drv_edge();
    smp();
    check("t5_after_busy", 64'(busy2), 64'd0);
    check("t5_after_aclr", 64'(mul2_aclr), 64'd0);
    check("t5_after_en", 64'(mul2_en), 64'd1);
    wait_cycles(14);
    check("t5_no_rsp", 64'(rq.size()), 64'd0);
    rq.delete();

    // ---- flush in the cycle a response is due ----
    drv_edge();
    req2 = 2'b10;
    req2_a[32 +: 32] = opa[5]; req2_b[32 +: 32] = opb[5];
    smp();
    check("t7_gnt1", 64'(gnt2), 64'b10);
    g = cyc;
    drv_edge();
    req2 = 2'b01;
    smp();
    check("t7_gnt0", 64'(gnt2), 64'b01);
    drv_edge();
    req2 = 2'b00;
    wait_cycles(6);
    drv_edge();
    flush = 1'b1;
    smp();
    $display("t7 flush cyc=%0d rsp_valid=%b id=%0d data=%08h", cyc, rsp2_valid, rsp2_id, rsp2_data);
    check("t7_due_valid", 64'(rsp2_valid), 64'd1);
    check("t7_due_id", 64'(rsp2_id), 64'd1);
    check("t7_due_data", 64'(rsp2_data), 64'(fp_mul(opa[5], opb[5])));
    drv_edge();
    flush = 1'b0;
    wait_cycles(6);
    check("t7_rsp_cnt", 64'(rq.size()), 64'd1);
    if (rq.size() > 0) check("t7_rsp_cyc", 64'(rq[0].c), 64'(g + 1 + LAT));
    rq.delete();

    // ---- 6: async reset mid-stream ----
    req2_a[0 +: 32] = opa[0]; req2_b[0 +: 32] = opb[0];
    drv_edge();
    req2 = 2'b01;
    smp();
    check("t6_pre_gnt", 64'(gnt2), 64'b01);
    wait_cycles(10);
    #1;
    check("t6_pre_busy_gnt", 64'(gnt2), 64'b01);
    check("t6_pre_rsp", 64'(rsp2_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    $display("t6 reset asserted: gnt=%b rsp_valid=%b aclr=%b", gnt2, rsp2_valid, mul2_aclr);
    check("t6_rst_gnt", 64'(gnt2), 64'd0);
    check("t6_rst_rsp", 64'(rsp2_valid), 64'd0);
    check("t6_rst_aclr", 64'(mul2_aclr), 64'd1);
    check("t6_rst_en", 64'(mul2_en), 64'd0);
    check("t6_rst_busy", 64'(busy2), 64'd1);
    req2 = 2'b00;
    drv_edge();
    reset = 1'b0;
    smp();
    check("t6_init1_aclr", 64'(mul2_aclr), 64'd1);
    drv_edge();
    req2 = 2'b01;
    smp();
    check("t6_init2_gnt", 64'(gnt2), 64'd0);
    check("t6_init2_aclr", 64'(mul2_aclr), 64'd1);
    drv_edge();
    rq.delete();
    eq.delete();
    req2_a[0 +: 32] = opa[2]; req2_b[0 +: 32] = opb[2];
    smp();
    $display("t6 first op cyc=%0d gnt=%b", cyc, gnt2);
    check("t6_gnt", 64'(gnt2), 64'b01);
    eq.push_back('{cyc, 0, opa[2], opb[2]});
    drv_edge();
    req2 = 2'b00;
    wait_cycles(12);
    verify_rsp("t6");

    // ---- 4: wrap-around on the NREQ=3 instance ----
    req3_a = {3{32'h40400000}};
    req3_b = {3{32'h3fc00000}};
    drv_edge();
    req3 = 3'b100;
    smp();
    $display("t4 cyc=%0d gnt3=%b", cyc, gnt3);
    check("t4_gnt", 64'(gnt3), 64'(exp_g3[0]));
    for (int k = 1; k < 4; k++) begin
      drv_edge();
      req3 = 3'b111;
      smp();
      $display("t4 cyc=%0d gnt3=%b", cyc, gnt3);
      check("t4_gnt", 64'(gnt3), 64'(exp_g3[k]));
    end
    drv_edge();
    req3 = 3'b000;
    wait_cycles(5);
    for (int k = 0; k < 4; k++) begin
      smp();
      $display("t4 rsp cyc=%0d valid=%b id=%0d data=%08h", cyc, rsp3_valid, rsp3_id, rsp3_data);
      check("t4_rsp_valid", 64'(rsp3_valid), 64'd1);
      check("t4_rsp_id", 64'(rsp3_id), 64'(exp_id3[k]));
      check("t4_rsp_data", 64'(rsp3_data), 64'(fp_mul(32'h40400000, 32'h3fc00000)));
      drv_edge();
    end
    smp();
    check("t4_rsp_end", 64'(rsp3_valid), 64'd0);
    check("t4_busy_end", 64'(busy3), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
